fp_div: RTL and testbench

Pipelined-handshake IEEE-754 single-precision divider, the inverse-operation companion to the team's FP multiplier in the chaotic-map datapath. It accepts one dividend/divisor pair, computes the quotient mantissa by iterative restoring division (one quotient bit per cycle), rounds to nearest-even, and holds the result until the consumer takes it. Denormals are flushed to zero on input and output.

---
 rtl/fp_pkg.sv | 58 +++++
 rtl/fp_mant_divider.sv | 73 +++++++
 rtl/fp_div.sv | 210 +++++++++++++++++++++
 tb/tb_fp_div.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared widths, enums, payload layout and operand classifier for the FP divider.
package fp_pkg;

    localparam int unsigned PRECISION = 32;
    localparam int unsigned EXPONENT  = 8;
    localparam int unsigned FRACTION  = 23;
    localparam int unsigned BIAS      = 127;

    localparam int unsigned MANT_W  = FRACTION + 1;        // mantissa with hidden one
    localparam int unsigned REM_W   = MANT_W + 1;          // remainder needs one headroom bit
    localparam int unsigned QUOT_W  = FRACTION + 3;        // quotient bits incl. guard position
    localparam int unsigned CNT_W   = $clog2(QUOT_W);
    localparam int unsigned EXP_W   = EXPONENT + 2;        // signed working exponent
    localparam int unsigned FLAGS_W = 4;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_DIV_ZERO  = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

    localparam logic [PRECISION-1:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ROUND,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } op_class_e;

    typedef struct packed {
        logic                sign;
        logic [EXPONENT-1:0] exp;
        logic [FRACTION-1:0] frac;
    } fp_word_t;

    // Classify an operand magnitude; denormals are treated as zero.
    function automatic op_class_e classify(input logic [PRECISION-2:0] mag);
        logic [EXPONENT-1:0] e;
        logic [FRACTION-1:0] f;
        e = mag[PRECISION-2:FRACTION];
        f = mag[FRACTION-1:0];
        if (e == '0) begin
            return ZERO;
        end else if (e == '1) begin
            return (f == '0) ? INF : NAN;
        end else begin
            return NORMAL;
        end
    endfunction

endpackage

// File: rtl/fp_mant_divider.sv
// Restoring mantissa divider: one quotient bit per cycle after a start pulse.
module fp_mant_divider
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MANT_W-1:0] r_init,
    input  logic [MANT_W-1:0] d_init,
    output logic              last_c,
    output logic              rem_nz_c,
    output logic [QUOT_W-1:0] quot
);

    logic [REM_W-1:0]  rem_q, rem_d;
    logic [MANT_W-1:0] div_q, div_d;
    logic [QUOT_W-1:0] quot_q, quot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic              r_ge_c;
    logic [MANT_W-1:0] r_sub_c;

    // One restoring step; the partial remainder always fits MANT_W bits after subtraction.
    always_comb begin
        r_ge_c  = rem_q >= {1'b0, div_q};
        r_sub_c = r_ge_c ? MANT_W'(rem_q - {1'b0, div_q}) : rem_q[MANT_W-1:0];

        rem_d  = rem_q;
        div_d  = div_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (start) begin
            rem_d  = {1'b0, r_init};
            div_d  = d_init;
            quot_d = '0;
            cnt_d  = CNT_W'(QUOT_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = {r_sub_c, 1'b0};
            quot_d = {quot_q[QUOT_W-2:0], r_ge_c};
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            div_q  <= div_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign last_c   = busy_q && (cnt_q == '0);
    assign rem_nz_c = |rem_q;
    assign quot     = quot_q;

endmodule

// File: rtl/fp_div.sv
// Single-precision divider: special-case decode, iterative mantissa divide, RNE rounding.
module fp_div
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRECISION-1:0] a_operand,
    input  logic [PRECISION-1:0] b_operand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRECISION-1:0] result,
    output logic [FLAGS_W-1:0]   flags
);

    localparam logic [PRECISION-2:0]    INF_MAG  = {{EXPONENT{1'b1}}, {FRACTION{1'b0}}};
    localparam logic [PRECISION-2:0]    ZERO_MAG = '0;
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);
    localparam logic signed [EXP_W-1:0] EXP_OVF  = EXP_W'((1 << EXPONENT) - 1);

    state_e                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [PRECISION-1:0]    result_q, result_d;
    logic [FLAGS_W-1:0]      flags_q, flags_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;

    op_class_e               cls_a_c, cls_b_c;
    logic                    special_c;
    logic [PRECISION-1:0]    spec_result_c;
    logic [FLAGS_W-1:0]      spec_flags_c;
    logic                    sign_in_c;
    logic signed [EXP_W-1:0] exp_in_c;

    logic                    div_start_c;
    logic                    div_last_c;
    logic                    div_rem_nz_c;
    logic [QUOT_W-1:0]       div_quot;

    logic [QUOT_W-1:0]       norm_c;
    logic signed [EXP_W-1:0] exp_n_c, exp_f_c;
    logic [MANT_W-1:0]       mant_c;
    logic                    guard_c, sticky_c, rnd_up_c;
    logic [MANT_W:0]         mant_r_c;
    logic [FRACTION-1:0]     frac_f_c;
    fp_word_t                rnd_word_c;
    logic [FLAGS_W-1:0]      rnd_flags_c;

    // Operand classification and special-case result, evaluated on the incoming pair.
    always_comb begin
        cls_a_c   = classify(a_operand[PRECISION-2:0]);
        cls_b_c   = classify(b_operand[PRECISION-2:0]);
        sign_in_c = a_operand[PRECISION-1] ^ b_operand[PRECISION-1];
        exp_in_c  = EXP_W'(a_operand[PRECISION-2:FRACTION])
                  - EXP_W'(b_operand[PRECISION-2:FRACTION])
                  + EXP_W'(BIAS);

        special_c     = 1'b1;
        spec_result_c = '0;
        spec_flags_c  = '0;

        if (cls_a_c == NAN || cls_b_c == NAN ||
            (cls_a_c == ZERO && cls_b_c == ZERO) ||
            (cls_a_c == INF  && cls_b_c == INF)) begin
            spec_result_c               = CANON_NAN;
            spec_flags_c[FLAG_INVALID]  = 1'b1;
        end else if (cls_a_c == NORMAL && cls_b_c == ZERO) begin
            spec_result_c               = {sign_in_c, INF_MAG};
            spec_flags_c[FLAG_DIV_ZERO] = 1'b1;
        end else if (cls_a_c == INF) begin
            spec_result_c = {sign_in_c, INF_MAG};
        end else if (cls_a_c == ZERO || cls_b_c == INF) begin
            spec_result_c = {sign_in_c, ZERO_MAG};
        end else begin
            special_c = 1'b0;
        end
    end

    fp_mant_divider u_mant_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start_c),
        .r_init   ({1'b1, a_operand[FRACTION-1:0]}),
        .d_init   ({1'b1, b_operand[FRACTION-1:0]}),
        .last_c   (div_last_c),
        .rem_nz_c (div_rem_nz_c),
        .quot     (div_quot)
    );

    // Normalize, round to nearest-even and range-check the finished quotient.
    always_comb begin
        if (div_quot[QUOT_W-1]) begin
            norm_c  = div_quot;
            exp_n_c = exp_q;
        end else begin
            norm_c  = {div_quot[QUOT_W-2:0], 1'b0};
            exp_n_c = exp_q - EXP_ONE;
        end

        mant_c   = norm_c[QUOT_W-1 -: MANT_W];
        guard_c  = norm_c[1];
        sticky_c = div_rem_nz_c | norm_c[0];
        rnd_up_c = guard_c & (sticky_c | mant_c[0]);
        mant_r_c = {1'b0, mant_c} + (MANT_W + 1)'(rnd_up_c);

        if (mant_r_c[MANT_W]) begin
            frac_f_c = mant_r_c[MANT_W-1:1];
            exp_f_c  = exp_n_c + EXP_ONE;
        end else begin
            frac_f_c = mant_r_c[FRACTION-1:0];
            exp_f_c  = exp_n_c;
        end

        rnd_word_c.sign = sign_q;
        rnd_word_c.exp  = exp_f_c[EXPONENT-1:0];
        rnd_word_c.frac = frac_f_c;
        rnd_flags_c     = '0;

        if (exp_f_c >= EXP_OVF) begin
            rnd_word_c.exp             = '1;
            rnd_word_c.frac            = '0;
            rnd_flags_c[FLAG_OVERFLOW] = 1'b1;
        end else if (exp_f_c <= EXP_ZERO) begin
            rnd_word_c.exp              = '0;
            rnd_word_c.frac             = '0;
            rnd_flags_c[FLAG_UNDERFLOW] = 1'b1;
        end
    end

    // Control FSM: next state, handshake and result loading.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        div_start_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (special_c) begin
                        result_d    = spec_result_c;
                        flags_d     = spec_flags_c;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        sign_d      = sign_in_c;
                        exp_d       = exp_in_c;
                        div_start_c = 1'b1;
                        state_d     = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (div_last_c) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                result_d    = rnd_word_c;
                flags_d     = rnd_flags_c;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: directed vectors, backpressure and mid-operation reset.
module tb_fp_div;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    fp_div dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial forever #5 clk = ~clk;

    // Edge index: after posedge k (NBA settled) cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Latency is counted in edges from the acceptance edge to the edge that raised out_valid.
    task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] flg, input int lat,
                        input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept actual=in_ready_low required=in_ready_high", name);
            return;
        end
        in_valid  = 1'b1;
        a_operand = a;
        b_operand = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        if (push) begin
            e.name = name;
            e.res  = res;
            e.flg  = flg;
            e.lat  = lat;
            e.acc  = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pop on the first cycle of each result, then watch it stay stable.
    exp_t cur;
    bit   seen = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            check("busy_in_ready", 32'(in_ready), 32'd0);
            if (!seen) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=0x%08h required=none", result);
                end else begin
                    cur = sb.pop_front();
                    check({cur.name, "_result"},  result,          cur.res);
                    check({cur.name, "_flags"},   32'(flags),      32'(cur.flg));
                    check({cur.name, "_latency"}, 32'(cyc - cur.acc), 32'(cur.lat));
                end
                seen = 1'b1;
            end else begin
                check({cur.name, "_hold_result"}, result,     cur.res);
                check({cur.name, "_hold_flags"},  32'(flags), 32'(cur.flg));
            end
            if (out_ready) seen = 1'b0;
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_operand = '0;
        b_operand = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result",    result,         32'd0);
        check("reset_flags",     32'(flags),     32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Normal path and rounding.
        send("six_div_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 1);
        send("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 27, 1);
        send("neg_one_div_three", 32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 4'b0000, 27, 1);
        send("one_div_one",  32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 27, 1);
        send("two_div_neg_half", 32'h4000_0000, 32'hBF00_0000, 32'hC080_0000, 4'b0000, 27, 1);
        // Special cases.
        send("neg_one_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 0, 1);
        send("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 0, 1);
        send("inf_div_inf",  32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 0, 1);
        send("nan_div_one",  32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 0, 1);
        send("one_div_inf",  32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000, 0, 1);
        send("inf_div_two",  32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0000, 0, 1);
        send("neginf_div_negzero", 32'hFF80_0000, 32'h8000_0000, 32'h7F80_0000, 4'b0000, 0, 1);
        // Range limits and denormal flush.
        send("overflow",     32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b0010, 27, 1);
        send("underflow",    32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0001, 27, 1);
        send("denormal",     32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 0, 1);
        drain();

        // Backpressure: result held, busy input pulses ignored.
        out_ready = 1'b0;
        send("bp_one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 27, 1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("bp_out_valid_rise", 32'(out_valid), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid  = (i % 2 == 0);
            a_operand = 32'h40C0_0000;
            b_operand = 32'h4000_0000;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        send("b2b_six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 1);
        send("b2b_neg_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 0, 1);
        drain();

        // Reset during DIVIDE iteration 10 aborts without emitting anything.
        send("aborted", 32'h40C0_0000, 32'h4000_0000, 32'h0, 4'b0000, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result",    result,         32'd0);
        check("abort_flags",     32'(flags),     32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        send("post_reset_six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27, 1);
        drain();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
